// File: rtl/mor1kx_pcu_ext.sv
// Parametrised performance counter unit for SPR group 7: popcount counting,
// saturate/wrap mode, sticky overflow with interrupt, and a registered one-cycle SPR ack.
module mor1kx_pcu_ext #(
  parameter int NUM_COUNTERS  = 8,
  parameter int COUNTER_WIDTH = 32,
  parameter int NUM_EVENTS    = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spr_access_i,
  input  logic                  spr_we_i,
  input  logic                  spr_re_i,
  input  logic [15:0]           spr_addr_i,
  input  logic [31:0]           spr_dat_i,
  output logic                  spr_bus_ack_o,
  output logic [31:0]           spr_dat_o,
  input  logic                  spr_sys_mode_i,
  input  logic [NUM_EVENTS-1:0] pcu_events_i,
  input  logic                  pcu_freeze_i,
  output logic                  pcu_irq_o
);

  localparam int CW = COUNTER_WIDTH;

  function automatic logic [7:0] popcount(input logic [NUM_EVENTS-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < NUM_EVENTS; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  logic [7:0]              blk_s;
  logic [2:0]              idx_s;
  logic                    unused_s;
  logic                    ack_r;
  logic [31:0]             dat_r;
  logic                    irq_r;
  logic                    req_s;
  logic                    wr_s;
  logic [CW-1:0]           cnt_a [NUM_COUNTERS];
  logic [31:0]             pcmr_a [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] irq_vec_s;
  logic [63:0]             cnt_sel_s;
  logic [31:0]             pcmr_sel_s;
  logic [31:0]             rdat_s;
  logic                    user_ok_s;

  assign blk_s    = spr_addr_i[10:3];
  assign idx_s    = spr_addr_i[2:0];
  assign unused_s = ^spr_addr_i[15:11];
  // A request held across its own ack cycle is not performed twice.
  assign req_s    = spr_access_i & (spr_we_i | spr_re_i) & ~ack_r;
  assign wr_s     = req_s & spr_we_i & spr_sys_mode_i;

  for (genvar n = 0; n < NUM_COUNTERS; n++) begin : g_cnt
    logic [CW-1:0]         cnt_r;
    logic                  umra_r, cism_r, cium_r, ovie_r, ov_r, sat_r;
    logic [NUM_EVENTS-1:0] en_r;
    logic                  sel_s, act_s, cr_wr_s, crh_wr_s, mr_wr_s, carry_s;
    logic [7:0]            inc_s;
    logic [CW:0]           sum_s;
    logic [63:0]           wext_s;
    logic [CW-1:0]         cnt_nxt_s;
    logic [31:0]           pcmr_s;

    assign sel_s    = (idx_s == 3'(n));
    assign cr_wr_s  = wr_s & sel_s & (blk_s == 8'd0);
    assign mr_wr_s  = wr_s & sel_s & (blk_s == 8'd1);
    assign crh_wr_s = wr_s & sel_s & (blk_s == 8'd2);
    assign act_s    = ~pcu_freeze_i & ((cism_r & spr_sys_mode_i) | (cium_r & ~spr_sys_mode_i));
    assign inc_s    = act_s ? popcount(pcu_events_i & en_r) : 8'd0;
    assign sum_s    = {1'b0, cnt_r} + (CW+1)'(inc_s);
    assign carry_s  = sum_s[CW];

    // Next counter value: an SPR write replaces one half and drops this cycle's increment.
    always_comb begin
      wext_s    = 64'(cnt_r);
      cnt_nxt_s = sum_s[CW-1:0];
      if (cr_wr_s) begin
        wext_s[31:0] = spr_dat_i;
        cnt_nxt_s    = CW'(wext_s);
      end else if (crh_wr_s) begin
        wext_s[63:32] = spr_dat_i;
        cnt_nxt_s     = CW'(wext_s);
      end else if (carry_s & sat_r) begin
        cnt_nxt_s = {CW{1'b1}};
      end else begin
        cnt_nxt_s = sum_s[CW-1:0];
      end
    end

    // Counter and mode register state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r  <= {CW{1'b0}};
        umra_r <= 1'b0;
        cism_r <= 1'b0;
        cium_r <= 1'b0;
        ovie_r <= 1'b0;
        ov_r   <= 1'b0;
        sat_r  <= 1'b0;
        en_r   <= {NUM_EVENTS{1'b0}};
      end else begin
        cnt_r <= cnt_nxt_s;
        // A clearing write loses against an overflow in the same cycle.
        ov_r  <= (ov_r & ~(mr_wr_s & spr_dat_i[27])) | (carry_s & ~(cr_wr_s | crh_wr_s));
        if (mr_wr_s) begin
          umra_r <= spr_dat_i[1];
          cism_r <= spr_dat_i[2];
          cium_r <= spr_dat_i[3];
          en_r   <= spr_dat_i[4 +: NUM_EVENTS];
          ovie_r <= spr_dat_i[26];
          sat_r  <= spr_dat_i[28];
        end else begin
          umra_r <= umra_r;
          cism_r <= cism_r;
          cium_r <= cium_r;
          en_r   <= en_r;
          ovie_r <= ovie_r;
          sat_r  <= sat_r;
        end
      end
    end

    // PCMR read image.
    always_comb begin
      pcmr_s                 = 32'd0;
      pcmr_s[0]              = 1'b1;
      pcmr_s[1]              = umra_r;
      pcmr_s[2]              = cism_r;
      pcmr_s[3]              = cium_r;
      pcmr_s[4 +: NUM_EVENTS] = en_r;
      pcmr_s[26]             = ovie_r;
      pcmr_s[27]             = ov_r;
      pcmr_s[28]             = sat_r;
    end

    assign cnt_a[n]     = cnt_r;
    assign pcmr_a[n]    = pcmr_s;
    assign irq_vec_s[n] = ov_r & ovie_r;
  end

  // Read mux; unimplemented slots contribute zero, including the CP bit.
  always_comb begin
    cnt_sel_s  = 64'd0;
    pcmr_sel_s = 32'd0;
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      cnt_sel_s  = cnt_sel_s | ((idx_s == 3'(n)) ? 64'(cnt_a[n]) : 64'd0);
      pcmr_sel_s = pcmr_sel_s | ((idx_s == 3'(n)) ? pcmr_a[n] : 32'd0);
    end
    user_ok_s = spr_sys_mode_i | pcmr_sel_s[1];
    case (blk_s)
      8'd0:    rdat_s = user_ok_s ? cnt_sel_s[31:0] : 32'd0;
      8'd1:    rdat_s = spr_sys_mode_i ? pcmr_sel_s : 32'd0;
      8'd2:    rdat_s = user_ok_s ? cnt_sel_s[63:32] : 32'd0;
      default: rdat_s = 32'd0;
    endcase
  end

  // Registered ack, read data and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
      dat_r <= 32'd0;
      irq_r <= 1'b0;
    end else begin
      ack_r <= req_s;
      dat_r <= (req_s & spr_re_i) ? rdat_s : 32'd0;
      irq_r <= |irq_vec_s;
    end
  end

  assign spr_bus_ack_o = ack_r;
  assign spr_dat_o     = dat_r;
  assign pcu_irq_o     = irq_r;

endmodule

// File: tb/tb_mor1kx_pcu_ext.sv
// Directed self-checking bench for mor1kx_pcu_ext (4 counters, 48-bit, 11 events).
module tb_mor1kx_pcu_ext;

  localparam int NC = 4;
  localparam int CW = 48;
  localparam int NE = 11;

  logic          clk;
  logic          rst_n;
  logic          spr_access_i;
  logic          spr_we_i;
  logic          spr_re_i;
  logic [15:0]   spr_addr_i;
  logic [31:0]   spr_dat_i;
  logic          spr_bus_ack_o;
  logic [31:0]   spr_dat_o;
  logic          spr_sys_mode_i;
  logic [NE-1:0] pcu_events_i;
  logic          pcu_freeze_i;
  logic          pcu_irq_o;

  int checks;
  int failures;

  mor1kx_pcu_ext #(
    .NUM_COUNTERS (NC),
    .COUNTER_WIDTH(CW),
    .NUM_EVENTS   (NE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .spr_access_i  (spr_access_i),
    .spr_we_i      (spr_we_i),
    .spr_re_i      (spr_re_i),
    .spr_addr_i    (spr_addr_i),
    .spr_dat_i     (spr_dat_i),
    .spr_bus_ack_o (spr_bus_ack_o),
    .spr_dat_o     (spr_dat_o),
    .spr_sys_mode_i(spr_sys_mode_i),
    .pcu_events_i  (pcu_events_i),
    .pcu_freeze_i  (pcu_freeze_i),
    .pcu_irq_o     (pcu_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the ack cycle.
  task automatic xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdat,
                      output logic [31:0] rdat);
    spr_access_i = 1'b1;
    spr_we_i     = we;
    spr_re_i     = ~we;
    spr_addr_i   = addr;
    spr_dat_i    = wdat;
    @(posedge clk); #1;
    check("ack_pulse", {63'd0, spr_bus_ack_o}, 64'd1);
    rdat         = spr_dat_o;
    spr_access_i = 1'b0;
    spr_we_i     = 1'b0;
    spr_re_i     = 1'b0;
    @(posedge clk); #1;
    check("ack_drop", {63'd0, spr_bus_ack_o}, 64'd0);
    check("dat_idle", {32'd0, spr_dat_o}, 64'd0);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] d);
    logic [31:0] dummy;
    xfer(1'b1, addr, d, dummy);
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    xfer(1'b0, addr, 32'd0, got);
    check(tag, {32'd0, got}, {32'd0, exp});
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    spr_access_i   = 1'b0;
    spr_we_i       = 1'b0;
    spr_re_i       = 1'b0;
    spr_addr_i     = 16'd0;
    spr_dat_i      = 32'd0;
    spr_sys_mode_i = 1'b1;
    pcu_events_i   = 11'd0;
    pcu_freeze_i   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {63'd0, spr_bus_ack_o}, 64'd0);
    check("rst_dat", {32'd0, spr_dat_o}, 64'd0);
    check("rst_irq", {63'd0, pcu_irq_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset values of PCMR and unmapped offsets
    rd("pcmr0_rst", 16'd8, 32'h0000_0001);
    rd("pcmr3_rst", 16'd11, 32'h0000_0001);
    rd("pcmr4_unimpl", 16'd12, 32'h0000_0000);
    rd("pcmr7_unimpl", 16'd15, 32'h0000_0000);
    rd("off24", 16'd24, 32'h0000_0000);
    rd("off7ff", 16'h07FF, 32'h0000_0000);

    // CISM|LA|SA, load+store for 10 cycles -> 20
    wr(16'd8, 32'h0000_0034);
    rd("pcmr0_las", 16'd8, 32'h0000_0035);
    pcu_events_i = 11'b000_0000_0011;
    repeat (10) @(posedge clk);
    #1;
    pcu_events_i = 11'd0;
    rd("pccr0_20", 16'd0, 32'd20);
    rd("pccrh0_0", 16'd16, 32'd0);
    pcu_freeze_i = 1'b1;
    pcu_events_i = 11'b000_0000_0011;
    repeat (5) @(posedge clk);
    #1;
    pcu_events_i = 11'd0;
    pcu_freeze_i = 1'b0;
    rd("pccr0_frozen", 16'd0, 32'd20);
    pcu_events_i = 11'h7FF;
    @(posedge clk); #1;
    pcu_events_i = 11'd0;
    rd("pccr0_masked", 16'd0, 32'd22);

    // 48-bit wrap with OVIE
    wr(16'd8, 32'h0400_0014);
    wr(16'd16, 32'h0000_FFFF);
    wr(16'd0, 32'hFFFF_FFFE);
    pcu_events_i = 11'd1;
    @(posedge clk); #1;
    check("irq_e1", {63'd0, pcu_irq_o}, 64'd0);
    @(posedge clk); #1;
    check("irq_e2", {63'd0, pcu_irq_o}, 64'd0);
    @(posedge clk); #1;
    check("irq_e3", {63'd0, pcu_irq_o}, 64'd1);
    pcu_events_i = 11'd0;
    rd("wrap_lo", 16'd0, 32'h0000_0001);
    rd("wrap_hi", 16'd16, 32'h0000_0000);
    rd("wrap_pcmr", 16'd8, 32'h0C00_0015);

    // Saturate mode
    wr(16'd8, 32'h1C00_0014);
    wr(16'd16, 32'h0000_FFFF);
    wr(16'd0, 32'hFFFF_FFFE);
    pcu_events_i = 11'd1;
    repeat (3) @(posedge clk);
    #1;
    pcu_events_i = 11'd0;
    rd("sat_lo", 16'd0, 32'hFFFF_FFFF);
    rd("sat_hi", 16'd16, 32'h0000_FFFF);
    rd("sat_pcmr", 16'd8, 32'h1C00_0015);
    check("sat_irq", {63'd0, pcu_irq_o}, 64'd1);

    // OV clear in the same cycle as an overflow: OV stays set
    pcu_events_i = 11'd1;
    spr_access_i = 1'b1;
    spr_we_i     = 1'b1;
    spr_addr_i   = 16'd8;
    spr_dat_i    = 32'h1C00_0014;
    @(posedge clk); #1;
    pcu_events_i = 11'd0;
    check("ovrace_ack", {63'd0, spr_bus_ack_o}, 64'd1);
    spr_access_i = 1'b0;
    spr_we_i     = 1'b0;
    @(posedge clk); #1;
    rd("ovrace_pcmr", 16'd8, 32'h1C00_0015);

    // OV clear: irq falls one cycle after the write edge
    spr_access_i = 1'b1;
    spr_we_i     = 1'b1;
    spr_addr_i   = 16'd8;
    spr_dat_i    = 32'h1C00_0014;
    @(posedge clk); #1;
    check("ovclr_ack", {63'd0, spr_bus_ack_o}, 64'd1);
    check("ovclr_irq_hold", {63'd0, pcu_irq_o}, 64'd1);
    spr_access_i = 1'b0;
    spr_we_i     = 1'b0;
    @(posedge clk); #1;
    check("ovclr_irq_fall", {63'd0, pcu_irq_o}, 64'd0);
    rd("ovclr_pcmr", 16'd8, 32'h1400_0015);

    // User-mode privilege
    wr(16'd16, 32'd0);
    wr(16'd0, 32'h0000_0055);
    wr(16'd8, 32'h0000_0014);
    spr_sys_mode_i = 1'b0;
    wr(16'd0, 32'h0000_1234);
    rd("user_noumra", 16'd0, 32'd0);
    spr_sys_mode_i = 1'b1;
    wr(16'd8, 32'h0000_0016);
    spr_sys_mode_i = 1'b0;
    rd("user_umra", 16'd0, 32'h0000_0055);
    rd("user_pcmr", 16'd8, 32'd0);
    spr_sys_mode_i = 1'b1;
    rd("sys_unchanged", 16'd0, 32'h0000_0055);

    // Write to PCCR1 during an enabled event: write wins only for counter 1
    wr(16'd9, 32'h0000_0014);
    pcu_events_i = 11'd1;
    spr_access_i = 1'b1;
    spr_we_i     = 1'b1;
    spr_addr_i   = 16'd1;
    spr_dat_i    = 32'h0000_0100;
    @(posedge clk); #1;
    pcu_events_i = 11'd0;
    check("wrrace_ack", {63'd0, spr_bus_ack_o}, 64'd1);
    spr_access_i = 1'b0;
    spr_we_i     = 1'b0;
    @(posedge clk); #1;
    rd("wrrace_pccr1", 16'd1, 32'h0000_0100);
    rd("wrrace_pccr0", 16'd0, 32'h0000_0056);
    wr(16'd5, 32'h0000_DEAD);
    rd("unimpl_pccr5", 16'd5, 32'd0);

    // Async reset mid-transaction
    wr(16'd16, 32'h0000_FFFF);
    wr(16'd0, 32'hFFFF_FFFF);
    wr(16'd8, 32'h0400_0014);
    pcu_events_i = 11'd1;
    @(posedge clk); #1;
    pcu_events_i = 11'd0;
    @(posedge clk); #1;
    check("pre_rst_irq", {63'd0, pcu_irq_o}, 64'd1);
    spr_access_i = 1'b1;
    spr_re_i     = 1'b1;
    spr_addr_i   = 16'd0;
    @(posedge clk); #1;
    check("pre_rst_ack", {63'd0, spr_bus_ack_o}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {63'd0, spr_bus_ack_o}, 64'd0);
    check("mid_rst_irq", {63'd0, pcu_irq_o}, 64'd0);
    check("mid_rst_dat", {32'd0, spr_dat_o}, 64'd0);
    spr_access_i = 1'b0;
    spr_re_i     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd("post_rst_pccr0", 16'd0, 32'd0);
    rd("post_rst_pccrh0", 16'd16, 32'd0);
    rd("post_rst_pccr1", 16'd1, 32'd0);
    rd("post_rst_pcmr0", 16'd8, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
